// File: rtl/regfile_pkg.sv
// Shared register-file types and the architectural register count for the hxd32 core.
// CONFIG_ISA_RV32E selects the 16-register embedded variant.
package regfile_pkg;

`ifdef CONFIG_ISA_RV32E
    localparam int REG_N_CFG = 16;
`else
    localparam int REG_N_CFG = 32;
`endif

    typedef logic [4:0] reg_addr_t;

    // Address 0 counts as valid (it reads as zero); only indices past the file are invalid.
    function automatic logic addr_valid(input reg_addr_t a, input int n);
        return int'(a) < n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations at issue, clears on writeback, flush drops all.
// Also answers busy lookups for every read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_N  = REG_N_CFG,
    parameter int NR     = 4,
    parameter int BYPASS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [31:0]          wr_hit_i,
    input  logic                 rsv_en_i,
    input  reg_addr_t            rsv_addr_i,
    input  logic                 flush_i,
    input  logic [NR-1:0][4:0]   rd_addr_i,
    output logic                 rsv_ok_o,
    output logic [NR-1:0]        rd_busy_o
);

    // Entry 0 and entries at or past REG_N are held at zero, so any 5-bit index is safe.
    logic [31:0] busy_q;

    // A register being written back this cycle may be re-reserved at once (WAW resolves here).
    always_comb begin
        rsv_ok_o = rsv_en_i & ~flush_i & addr_valid(rsv_addr_i, REG_N)
                 & (~busy_q[rsv_addr_i] | wr_hit_i[rsv_addr_i]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0 || r >= REG_N || flush_i) begin
                    busy_q[r] <= 1'b0;
                end else if (rsv_ok_o && rsv_addr_i == 5'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if (wr_hit_i[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[k]]
                         & ~((BYPASS != 0) & wr_hit_i[rd_addr_i[k]]);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-port priority, optional write-to-read
// bypass and a busy scoreboard for RAW/WAW stalls.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_N  = REG_N_CFG,
    parameter int NR     = 4,
    parameter int NW     = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NW-1:0]            wr_en_i,
    input  logic [NW-1:0][4:0]       wr_addr_i,
    input  logic [NW-1:0][XLEN-1:0]  wr_data_i,
    input  logic [NR-1:0][4:0]       rd_addr_i,
    output logic [NR-1:0][XLEN-1:0]  rd_data_o,
    output logic [NR-1:0]            rd_busy_o,
    input  logic                     rsv_en_i,
    input  reg_addr_t                rsv_addr_i,
    output logic                     rsv_ok_o,
    input  logic                     flush_i
);

    logic [XLEN-1:0] regs_q [32];
    logic [31:0]     wr_hit;
    logic [XLEN-1:0] wr_val [32];

    // Per-register winning write: scanning ports upward lets the highest index win.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int p = 0; p < NW; p++) begin
                if (wr_en_i[p] && wr_addr_i[p] == 5'(r) && r != 0
                    && addr_valid(5'(r), REG_N)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
        end
    end

    // Unwritable entries never leave zero, so reads need no separate address guard.
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            if (BYPASS != 0 && wr_hit[rd_addr_i[k]]) begin
                rd_data_o[k] = wr_val[rd_addr_i[k]];
            end else begin
                rd_data_o[k] = regs_q[rd_addr_i[k]];
            end
        end
    end

    regfile_scoreboard #(
        .REG_N  (REG_N),
        .NR     (NR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_hit_i   (wr_hit),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .flush_i    (flush_i),
        .rd_addr_i  (rd_addr_i),
        .rsv_ok_o   (rsv_ok_o),
        .rd_busy_o  (rd_busy_o)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a 32-register bypassing instance and a 16-register
// non-bypassing instance share stimulus and are checked against a behavioural model.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int NR = 4;
    localparam int NW = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NW-1:0]          wr_en;
    logic [NW-1:0][4:0]     wr_addr;
    logic [NW-1:0][31:0]    wr_data;
    logic [NR-1:0][4:0]     rd_addr;
    logic [NR-1:0][31:0]    rd_data [2];
    logic [NR-1:0]          rd_busy [2];
    logic                   rsv_en;
    reg_addr_t              rsv_addr;
    logic                   rsv_ok [2];
    logic                   flush;

    int total = 0;
    int bad   = 0;

    regfile_mp_sb #(.XLEN(32), .REG_N(32), .NR(NR), .NW(NW), .BYPASS(1)) u_dut_byp (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]),
        .rd_busy_o(rd_busy[0]), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .rsv_ok_o(rsv_ok[0]), .flush_i(flush)
    );

    regfile_mp_sb #(.XLEN(32), .REG_N(16), .NR(NR), .NW(NW), .BYPASS(0)) u_dut_e (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]),
        .rd_busy_o(rd_busy[1]), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .rsv_ok_o(rsv_ok[1]), .flush_i(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [2][32];
    logic        mbusy [2][32];

    function automatic int rn(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic bit bp(input int i);
        return i == 0;
    endfunction

    function automatic bit writable(input int i, input int a);
        return a != 0 && a < rn(i);
    endfunction

    function automatic bit written(input int a);
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && int'(wr_addr[p]) == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(input int i, input int a);
        if (!writable(i, a)) return 32'h0;
        if (bp(i))
            for (int p = NW - 1; p >= 0; p--)
                if (wr_en[p] && int'(wr_addr[p]) == a) return wr_data[p];
        return mregs[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input int a);
        if (!writable(i, a)) return 1'b0;
        return mbusy[i][a] && !(bp(i) && written(a));
    endfunction

    function automatic logic exp_ok(input int i);
        int a;
        a = int'(rsv_addr);
        if (!rsv_en || flush || a >= rn(i)) return 1'b0;
        return !mbusy[i][a] || written(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                for (int r = 0; r < 32; r++) begin
                    mregs[i][r] <= 32'h0;
                    mbusy[i][r] <= 1'b0;
                end
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < NW; p++)
                    if (wr_en[p] && writable(i, int'(wr_addr[p]))) begin
                        mregs[i][wr_addr[p]] <= wr_data[p];
                        mbusy[i][wr_addr[p]] <= 1'b0;
                    end
                if (exp_ok(i) && writable(i, int'(rsv_addr)))
                    mbusy[i][rsv_addr] <= 1'b1;
                if (flush)
                    for (int r = 0; r < 32; r++) mbusy[i][r] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("model rd_data[%0d] dut%0d a=%0d", k, i, rd_addr[k]),
                    rd_data[i][k], exp_data(i, int'(rd_addr[k])));
                chk($sformatf("model rd_busy[%0d] dut%0d a=%0d", k, i, rd_addr[k]),
                    32'(rd_busy[i][k]), 32'(exp_busy(i, int'(rd_addr[k]))));
            end
            chk($sformatf("model rsv_ok dut%0d a=%0d", i, rsv_addr),
                32'(rsv_ok[i]), 32'(exp_ok(i)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1; wr_addr[p] = 5'(a); wr_data[p] = d;
    endtask

    task automatic rsv(input int a);
        rsv_en = 1'b1; rsv_addr = 5'(a);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        rd_addr = {5'd7, 5'd31, 5'd5, 5'd1};
        #3;
        for (int i = 0; i < 2; i++) chk("reset rd_data[2]", rd_data[i][2], 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        // read every address on all ports after reset
        for (int j = 0; j < 8; j++) begin
            cyc();
            for (int k = 0; k < NR; k++) rd_addr[k] = 5'(4 * j + k);
            #2;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < NR; k++) begin
                    chk("post-reset read", rd_data[i][k], 32'h0);
                    chk("post-reset busy", 32'(rd_busy[i][k]), 32'h0);
                end
        end

        cyc(); wr(0, 5, 32'hDEADBEEF);
        cyc(); rd_addr[0] = 5'd5; #2;
        chk("x5 readback byp", rd_data[0][0], 32'hDEADBEEF);
        chk("x5 readback e",   rd_data[1][0], 32'hDEADBEEF);

        cyc(); wr(0, 0, 32'h1234); wr(1, 20, 32'h55);
        cyc(); rd_addr[0] = 5'd0; rd_addr[1] = 5'd20; rsv(20); #2;
        chk("x0 stays zero byp", rd_data[0][0], 32'h0);
        chk("x0 stays zero e",   rd_data[1][0], 32'h0);
        chk("x20 in range byp",  rd_data[0][1], 32'h55);
        chk("x20 out of range e", rd_data[1][1], 32'h0);
        chk("rsv x20 byp", 32'(rsv_ok[0]), 32'h1);
        chk("rsv x20 e",   32'(rsv_ok[1]), 32'h0);

        cyc(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd_addr[0] = 5'd7; #2;
        chk("x7 same-cycle byp", rd_data[0][0], 32'h2222);
        chk("x7 same-cycle e",   rd_data[1][0], 32'h0);
        cyc(); rd_addr[0] = 5'd7; #2;
        chk("x7 next byp", rd_data[0][0], 32'h2222);
        chk("x7 next e",   rd_data[1][0], 32'h2222);

        cyc(); rsv(3); #2;
        chk("rsv x3 first", 32'(rsv_ok[0]), 32'h1);
        cyc(); rd_addr[0] = 5'd3; rsv(3); #2;
        for (int i = 0; i < 2; i++) begin
            chk("x3 busy", 32'(rd_busy[i][0]), 32'h1);
            chk("rsv x3 again refused", 32'(rsv_ok[i]), 32'h0);
        end
        cyc(); wr(0, 3, 32'hAA); rsv(3); rd_addr[0] = 5'd3; #2;
        chk("waw rsv ok byp", 32'(rsv_ok[0]), 32'h1);
        chk("waw rsv ok e",   32'(rsv_ok[1]), 32'h1);
        chk("waw busy bypassed", 32'(rd_busy[0][0]), 32'h0);
        chk("waw busy e", 32'(rd_busy[1][0]), 32'h1);
        cyc(); rd_addr[0] = 5'd3; #2;
        for (int i = 0; i < 2; i++) begin
            chk("x3 still busy", 32'(rd_busy[i][0]), 32'h1);
            chk("x3 data", rd_data[i][0], 32'hAA);
        end
        cyc(); wr(1, 3, 32'hBB); rd_addr[0] = 5'd3; #2;
        chk("x3 wb busy byp", 32'(rd_busy[0][0]), 32'h0);
        chk("x3 wb busy e",   32'(rd_busy[1][0]), 32'h1);
        cyc(); rd_addr[0] = 5'd3; #2;
        chk("x3 cleared byp", 32'(rd_busy[0][0]), 32'h0);
        chk("x3 cleared e",   32'(rd_busy[1][0]), 32'h0);

        cyc(); rsv(1);
        cyc(); rsv(2);
        cyc(); rsv(4);
        cyc(); flush = 1'b1; rsv(9); rd_addr[0] = 5'd1; #2;
        chk("flush rsv byp", 32'(rsv_ok[0]), 32'h0);
        chk("flush rsv e",   32'(rsv_ok[1]), 32'h0);
        chk("x1 busy pre-flush", 32'(rd_busy[0][0]), 32'h1);
        cyc(); rd_addr = {5'd9, 5'd4, 5'd2, 5'd1}; #2;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NR; k++) chk("post-flush busy", 32'(rd_busy[i][k]), 32'h0);

        // random traffic with an asynchronous reset pulse mid-run
        for (int n = 0; n < 10000; n++) begin
            cyc();
            if (n == 5002) rst_n = 1'b1;
            wr_en = 2'($urandom);
            for (int p = 0; p < NW; p++) begin
                wr_addr[p] = rnd_addr();
                wr_data[p] = $urandom;
            end
            for (int k = 0; k < NR; k++) rd_addr[k] = rnd_addr();
            rsv_en = 1'($urandom);
            rsv_addr = rnd_addr();
            flush = ($urandom_range(0, 31) == 0);
            if (n == 5000) begin
                wr_en = '0;
                #2 rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < NR; k++) begin
                        chk("async reset data", rd_data[i][k], 32'h0);
                        chk("async reset busy", 32'(rd_busy[i][k]), 32'h0);
                    end
            end
        end

        cyc();
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
